// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared register-file and writeback-requester constants
package cpu_defs;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MULDIV = 2;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin picker: first valid at or after ptr wins
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= N) cand = cand - N;
            cand_idx = IDX_W'(cand);
            if (!any_o && valid_i[cand_idx]) begin
                any_o           = 1'b1;
                grant_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port among writeback sources
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = cpu_defs::DATA_W,
    parameter int ADDR_W  = cpu_defs::ADDR_W,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      freeze,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      rf_reg_write,
    output logic [ADDR_W-1:0]         rf_write_reg,
    output logic [DATA_W-1:0]         rf_write_data,
    output logic [2:0]                grant_id,
    input  logic [ADDR_W-1:0]         query_reg1,
    input  logic [ADDR_W-1:0]         query_reg2,
    output logic                      query_busy1,
    output logic                      query_busy2,
    output logic [CNT_W-1:0]          contention_count
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   win_idx;
    logic               any_win;
    logic               transfer;
    logic [ADDR_W-1:0]  sel_reg;
    logic [DATA_W-1:0]  sel_data;

    logic               we_q, we_d;
    logic [ADDR_W-1:0]  reg_q, reg_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [2:0]         gid_q, gid_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(PTR_W)) u_rr (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (any_win)
    );

    // Grant depends only on valids and pointer, never on the requester's data.
    assign req_ready = (reset || freeze) ? '0 : grant;
    assign transfer  = any_win && !reset && !freeze;
    assign sel_reg   = req_reg[win_idx*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[win_idx*DATA_W +: DATA_W];

    always_comb begin
        we_d   = 1'b0;
        reg_d  = reg_q;
        data_d = data_q;
        gid_d  = gid_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        if (transfer) begin
            we_d   = (sel_reg != ADDR_W'(cpu_defs::REG_ZERO));
            reg_d  = sel_reg;
            data_d = sel_data;
            gid_d  = 3'(win_idx);
            ptr_d  = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
        if (!freeze && ($countones(req_valid) > 1) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q   <= 1'b0;
            reg_q  <= '0;
            data_q <= '0;
            gid_q  <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            we_q   <= we_d;
            reg_q  <= reg_d;
            data_q <= data_d;
            gid_q  <= gid_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rf_reg_write     = we_q;
    assign rf_write_reg     = reg_q;
    assign rf_write_data    = data_q;
    assign grant_id         = gid_q;
    assign contention_count = cnt_q;

    // A destination is busy if it is in the output stage or any requester is asking for it.
    always_comb begin
        query_busy1 = we_q && (reg_q == query_reg1);
        query_busy2 = we_q && (reg_q == query_reg2);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && (req_reg[i*ADDR_W +: ADDR_W] == query_reg1)) query_busy1 = 1'b1;
            if (req_valid[i] && (req_reg[i*ADDR_W +: ADDR_W] == query_reg2)) query_busy2 = 1'b1;
        end
        if (query_reg1 == ADDR_W'(cpu_defs::REG_ZERO)) query_busy1 = 1'b0;
        if (query_reg2 == ADDR_W'(cpu_defs::REG_ZERO)) query_busy2 = 1'b0;
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench with a behavioural reference model
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        freeze = 1'b0;
    logic [2:0]  valid = '0;
    logic [4:0]  regs [3];
    logic [31:0] datas [3];
    logic [14:0] req_reg;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rf_reg_write;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic [2:0]  grant_id;
    logic [4:0]  q1 = '0, q2 = '0;
    logic        busy1, busy2;
    logic [15:0] contention_count;

    int nvec = 0;
    int nerr = 0;

    int          m_ptr = 0;
    bit          m_we = 0;
    logic [4:0]  m_reg = '0;
    logic [31:0] m_data = '0;
    int          m_gid = 0;
    int          m_cnt = 0;
    int          last_w = -1;

    assign req_reg  = {regs[2], regs[1], regs[0]};
    assign req_data = {datas[2], datas[1], datas[0]};

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .freeze           (freeze),
        .req_valid        (valid),
        .req_ready        (req_ready),
        .req_reg          (req_reg),
        .req_data         (req_data),
        .rf_reg_write     (rf_reg_write),
        .rf_write_reg     (rf_write_reg),
        .rf_write_data    (rf_write_data),
        .grant_id         (grant_id),
        .query_reg1       (q1),
        .query_reg2       (q2),
        .query_busy1      (busy1),
        .query_busy2      (busy2),
        .contention_count (contention_count)
    );

    function automatic int winner();
        if (reset || freeze) return -1;
        for (int k = 0; k < 3; k++) begin
            if (valid[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [2:0] exp_ready();
        int w;
        w = winner();
        return (w < 0) ? 3'b000 : (3'b001 << w);
    endfunction

    function automatic logic exp_busy(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        if (m_we && m_reg == q) return 1'b1;
        for (int i = 0; i < 3; i++) if (valid[i] && regs[i] == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        int w, pc;
        w = winner();
        pc = $countones(valid);
        last_w = w;
        @(posedge clk);
        if (reset) begin
            m_we = 0; m_reg = '0; m_data = '0; m_gid = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (!freeze && pc > 1 && m_cnt != 65535) m_cnt++;
            if (w >= 0) begin
                m_we = (regs[w] != 5'd0); m_reg = regs[w]; m_data = datas[w];
                m_gid = w; m_ptr = (w + 1) % 3;
            end else begin
                m_we = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin regs[i] = '0; datas[i] = '0; end
        reset = 1; valid = 3'b111; #1;
        nvec++; if (req_ready !== 3'b000) begin $display("FAIL reset_ready_comb got %b expected 000", req_ready); nerr++; end
        tick(); tick();
        reset = 0; valid = '0; q1 = 5'd3; q2 = 5'd7; #1;
        for (int c = 0; c < 3; c++) begin
            nvec++; if ({rf_reg_write, rf_write_reg, rf_write_data, grant_id} !== '0) begin
                $display("FAIL reset_outputs cyc%0d got we=%b reg=%0d data=%h gid=%0d expected all 0", c, rf_reg_write, rf_write_reg, rf_write_data, grant_id); nerr++; end
            nvec++; if (req_ready !== 3'b000 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
                $display("FAIL reset_idle cyc%0d got ready=%b busy=%b%b expected 000 00", c, req_ready, busy1, busy2); nerr++; end
            nvec++; if (contention_count !== 16'd0) begin $display("FAIL reset_count got %0d expected 0", contention_count); nerr++; end
            tick();
        end
    endtask

    task automatic test_single();
        valid = 3'b001; regs[0] = 5'd5; datas[0] = 32'hDEADBEEF; #1;
        nvec++; if (req_ready !== 3'b001) begin $display("FAIL single_ready got %b expected 001", req_ready); nerr++; end
        tick(); valid = '0; #1;
        nvec++; if (rf_reg_write !== 1'b1 || rf_write_reg !== 5'd5 || rf_write_data !== 32'hDEADBEEF || grant_id !== 3'd0) begin
            $display("FAIL single_write got we=%b reg=%0d data=%h gid=%0d expected 1 5 deadbeef 0", rf_reg_write, rf_write_reg, rf_write_data, grant_id); nerr++; end
        tick();
        nvec++; if (rf_reg_write !== 1'b0 || rf_write_reg !== 5'd5) begin
            $display("FAIL single_idle got we=%b reg=%0d expected 0 5", rf_reg_write, rf_write_reg); nerr++; end
    endtask

    task automatic test_all_three();
        reset = 1; tick(); reset = 0;
        valid = 3'b111; regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd3; #1;
        for (int k = 0; k < 6; k++) begin
            nvec++; if (req_ready !== (3'b001 << (k % 3))) begin
                $display("FAIL rr_ready k%0d got %b expected %b", k, req_ready, 3'b001 << (k % 3)); nerr++; end
            tick();
            nvec++; if (grant_id !== 3'(k % 3) || rf_write_reg !== 5'(k % 3 + 1) || rf_reg_write !== 1'b1) begin
                $display("FAIL rr_grant k%0d got gid=%0d reg=%0d we=%b expected %0d %0d 1", k, grant_id, rf_write_reg, rf_reg_write, k % 3, k % 3 + 1); nerr++; end
        end
        valid = '0; #1;
        nvec++; if (contention_count !== 16'd6) begin $display("FAIL rr_count got %0d expected 6", contention_count); nerr++; end
        tick();
    endtask

    task automatic test_reg0();
        valid = 3'b001; regs[0] = 5'd0; datas[0] = 32'h1234; q1 = 5'd0; #1;
        nvec++; if (busy1 !== 1'b0 || req_ready !== exp_ready()) begin
            $display("FAIL reg0_req got busy1=%b ready=%b expected 0 %b", busy1, req_ready, exp_ready()); nerr++; end
        tick(); valid = '0; #1;
        nvec++; if (rf_reg_write !== 1'b0 || rf_write_data !== 32'h1234 || rf_write_reg !== 5'd0) begin
            $display("FAIL reg0_write got we=%b data=%h reg=%0d expected 0 1234 0", rf_reg_write, rf_write_data, rf_write_reg); nerr++; end
        nvec++; if (busy1 !== 1'b0) begin $display("FAIL reg0_busy got %b expected 0", busy1); nerr++; end
        tick();
    endtask

    task automatic test_busy();
        valid = 3'b010; regs[1] = 5'd9; datas[1] = 32'hA5A5_0009; q1 = 5'd9; q2 = 5'd10; #1;
        nvec++; if (busy1 !== 1'b1 || busy2 !== 1'b0) begin $display("FAIL busy_pending got %b%b expected 10", busy1, busy2); nerr++; end
        tick(); valid = '0; #1;
        nvec++; if (busy1 !== 1'b1 || rf_reg_write !== 1'b1 || grant_id !== 3'd1) begin
            $display("FAIL busy_output got busy1=%b we=%b gid=%0d expected 1 1 1", busy1, rf_reg_write, grant_id); nerr++; end
        tick();
        nvec++; if (busy1 !== 1'b0) begin $display("FAIL busy_cleared got %b expected 0", busy1); nerr++; end
    endtask

    task automatic test_freeze();
        int cnt0;
        valid = 3'b001; regs[0] = 5'd7; datas[0] = 32'h77; #1;
        tick();
        freeze = 1; valid = 3'b101; regs[2] = 5'd12; datas[2] = 32'hCC; cnt0 = m_cnt; #1;
        nvec++; if (rf_reg_write !== 1'b1 || rf_write_reg !== 5'd7) begin
            $display("FAIL freeze_inflight got we=%b reg=%0d expected 1 7", rf_reg_write, rf_write_reg); nerr++; end
        for (int c = 0; c < 3; c++) begin
            nvec++; if (req_ready !== 3'b000) begin $display("FAIL freeze_ready c%0d got %b expected 000", c, req_ready); nerr++; end
            tick();
        end
        nvec++; if (contention_count !== 16'(cnt0) || rf_reg_write !== 1'b0) begin
            $display("FAIL freeze_hold got cnt=%0d we=%b expected %0d 0", contention_count, rf_reg_write, cnt0); nerr++; end
        freeze = 0; #1;
        nvec++; if (req_ready !== exp_ready() || req_ready === 3'b000) begin
            $display("FAIL freeze_resume got %b expected %b", req_ready, exp_ready()); nerr++; end
        tick(); valid[last_w] = 1'b0; #1;
        nvec++; if (req_ready !== exp_ready()) begin $display("FAIL freeze_second got %b expected %b", req_ready, exp_ready()); nerr++; end
        tick(); valid = '0; tick();
    endtask

    task automatic test_reset_mid();
        valid = 3'b001; regs[0] = 5'd4; #1;
        tick();
        reset = 1; valid = 3'b011; #1;
        nvec++; if (req_ready !== 3'b000 || rf_reg_write !== 1'b1) begin
            $display("FAIL rstmid_during got ready=%b we=%b expected 000 1", req_ready, rf_reg_write); nerr++; end
        tick(); reset = 0; #1;
        nvec++; if (rf_reg_write !== 1'b0 || contention_count !== 16'd0) begin
            $display("FAIL rstmid_drop got we=%b cnt=%0d expected 0 0", rf_reg_write, contention_count); nerr++; end
        nvec++; if (req_ready !== 3'b001) begin $display("FAIL rstmid_ptr got %b expected 001", req_ready); nerr++; end
        tick(); valid = '0; tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!valid[i] && $urandom_range(0, 1) == 1) begin
                    valid[i] = 1'b1; regs[i] = 5'($urandom_range(0, 7)); datas[i] = $urandom;
                end
            end
            freeze = ($urandom_range(0, 7) == 0);
            q1 = 5'($urandom_range(0, 7)); q2 = 5'($urandom_range(0, 7)); #1;
            nvec++; if (req_ready !== exp_ready()) begin $display("FAIL rnd_ready c%0d got %b expected %b", c, req_ready, exp_ready()); nerr++; end
            nvec++; if (busy1 !== exp_busy(q1) || busy2 !== exp_busy(q2)) begin
                $display("FAIL rnd_busy c%0d got %b%b expected %b%b", c, busy1, busy2, exp_busy(q1), exp_busy(q2)); nerr++; end
            tick();
            if (last_w >= 0) valid[last_w] = 1'b0;
            nvec++; if (rf_reg_write !== m_we || rf_write_reg !== m_reg || rf_write_data !== m_data || grant_id !== 3'(m_gid)) begin
                $display("FAIL rnd_out c%0d got we=%b reg=%0d data=%h gid=%0d expected %b %0d %h %0d",
                         c, rf_reg_write, rf_write_reg, rf_write_data, grant_id, m_we, m_reg, m_data, m_gid); nerr++; end
            nvec++; if (contention_count !== 16'(m_cnt)) begin $display("FAIL rnd_count c%0d got %0d expected %0d", c, contention_count, m_cnt); nerr++; end
        end
        freeze = 0; valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_all_three();
        test_reg0();
        test_busy();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32x32 register file between NUM_REQ writeback sources (ALU, load unit, multi-cycle mul/div). Round-robin arbitration with valid/ready handshake; the winning write is registered and presented to the register file one cycle later. Also provides pending-write lookups for the hazard/stall logic, plus a contention performance counter.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 5, register index width
CNT_W, 16, contention counter width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
freeze  input  1  suppresses all grants while high
req_valid  input  NUM_REQ  per-requester write request
req_ready  output  NUM_REQ  per-requester grant/accept (one-hot or zero)
req_reg  input  NUM_REQ*ADDR_W  destination index, requester i at bits [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  write data, same packing
rf_reg_write  output  1  to register file write enable
rf_write_reg  output  ADDR_W  to register file write index
rf_write_data  output  DATA_W  to register file write data
grant_id  output  3  index of requester whose write is on rf_* this cycle
query_reg1  input  ADDR_W  source index 1 from decode
query_reg2  input  ADDR_W  source index 2 from decode
query_busy1  output  1  write to query_reg1 in flight
query_busy2  output  1  write to query_reg2 in flight
contention_count  output  CNT_W  cycles with more than one req_valid

Behaviour:
- Reset (reset=1 at edge): rf_reg_write=0, rf_write_reg=0, rf_write_data=0, grant_id=0, rr_ptr=0, contention_count=0. While reset is high, req_ready=0 combinationally.
- Grant (combinational): if freeze=0 and reset=0, the winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[winner]=1; all other bits 0. No valid requests -> req_ready=0.
- Handshake: transfer occurs when req_valid[i] && req_ready[i] at the edge. Requesters hold valid, reg and data stable until accepted. req_ready must not depend on the requester's own data.
- Output stage: on transfer, the next cycle shows rf_write_reg=req_reg[w], rf_write_data=req_data[w], grant_id=w.
  - rf_reg_write=1 only if req_reg[w]!=0.
  - A write to register 0 is accepted (consumed) but never enables the write.
  - With no transfer, rf_reg_write=0 next cycle; rf_write_reg, rf_write_data and grant_id hold their values.
  - Latency: request accept to register-file write edge is exactly 1 cycle. Throughput is 1 write per cycle.
- Pointer: on transfer, rr_ptr <= (w+1) mod NUM_REQ; otherwise it holds. Freeze holds rr_ptr.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 grants.
- Busy query: query_busyN=1 iff query_regN!=0 and either:
  - rf_reg_write=1 and rf_write_reg==query_regN, or
  - some req_valid[i]=1 with req_reg[i]==query_regN.
  This is combinational and ignores freeze.
- Same destination from two requesters in one cycle: serialized in grant order. Program ordering is upstream's responsibility.
- contention_count: increments when popcount(req_valid)>1 and freeze=0; saturates at all-ones.
- Freeze mid-stream: no new accepts; a write already in the output stage still completes next edge.
- Reset mid-operation: the in-flight output write is dropped (rf_reg_write=0 next cycle); pending requests are not accepted.

Decomposition:
- Shared cpu_defs package: REG_ZERO=5'd0, ADDR_W, DATA_W, requester index constants (REQ_ALU=0, REQ_LOAD=1, REQ_MULDIV=2).
- Natural sub-module: rr_arbiter (valid vector + rr_ptr -> one-hot grant + encoded index). It is reusable for the memory-port arbiter.

Test Plan:
- Reset then idle: all outputs 0, req_ready=0, busy=0 for 3 cycles.
- Single request: ALU valid, reg=5, data=0xDEADBEEF -> req_ready[0]=1 that cycle; next cycle rf_reg_write=1, rf_write_reg=5, rf_write_data=0xDEADBEEF, grant_id=0.
- All three valid for 6 cycles, regs 1/2/3: grants 0,1,2,0,1,2; contention_count=6 at end; no double-accept.
- Write to reg 0 with data 0x1234: accepted, rf_reg_write stays 0; query_reg1=0 -> busy1=0.
- Busy: load valid for reg 9, query_reg1=9 -> busy1=1; after accept, busy1=1 during the output cycle, then 0.
- freeze=1 with two requests pending: req_ready=0, counter holds, rr_ptr holds; on release, arbitration resumes from the prior pointer. Reset asserted with the output stage valid -> rf_reg_write=0 next cycle, rr_ptr=0.
